unidade_controle_multiciclo: RTL and testbench

UNIDADE_CONTROLE_MULTICICLO -- requirements
Module: unidade_controle_multiciclo

---
 rtl/mips_pkg.sv | 51 +++++
 rtl/unidade_controle_multiciclo_decodificador.sv | 34 +++
 rtl/unidade_controle_multiciclo.sv | 169 ++++++++++++++++
 tb/tb_unidade_controle_multiciclo.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the multi-cycle control unit: opcodes, ALU/PC-source codes, state and class encodings.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package mips_pkg;

    // Opcode field IR[15:12] and R-type function field IR[3:0]
    localparam logic [3:0] OPC_TIPO_R = 4'b0000;
    localparam logic [3:0] OPC_ADDI   = 4'b0001;
    localparam logic [3:0] OPC_SLTI   = 4'b0010;
    localparam logic [3:0] OPC_BEQ    = 4'b0011;
    localparam logic [3:0] OPC_LW     = 4'b0100;
    localparam logic [3:0] OPC_SW     = 4'b0101;
    localparam logic [3:0] OPC_J      = 4'b0110;
    localparam logic [3:0] FUNCAO_JR  = 4'b1000;

    // ALU operation select
    localparam logic [1:0] ULA_TIPO_R = 2'b00;
    localparam logic [1:0] ULA_SOMA   = 2'b01;
    localparam logic [1:0] ULA_SLT    = 2'b10;
    localparam logic [1:0] ULA_SUB    = 2'b11;

    // Next-PC source select
    localparam logic [1:0] PC_MAIS1  = 2'b00;
    localparam logic [1:0] PC_DESVIO = 2'b01;
    localparam logic [1:0] PC_SALTO  = 2'b10;
    localparam logic [1:0] PC_REG_RS = 2'b11;

    // ALU operand B select
    localparam logic [1:0] FONTE_B_REG  = 2'b00;
    localparam logic [1:0] FONTE_B_IMED = 2'b10;

    typedef enum logic [2:0] {
        BUSCA      = 3'd0,
        DECODIFICA = 3'd1,
        EXECUTA    = 3'd2,
        MEMORIA    = 3'd3,
        ESCRITA    = 3'd4
    } estado_t;

    typedef enum logic [2:0] {
        CL_TIPO_R   = 3'd0,
        CL_ADDI     = 3'd1,
        CL_SLTI     = 3'd2,
        CL_BEQ      = 3'd3,
        CL_LW       = 3'd4,
        CL_SW       = 3'd5,
        CL_J        = 3'd6,
        CL_INVALIDA = 3'd7
    } classe_t;

endpackage

// File: rtl/unidade_controle_multiciclo_decodificador.sv
// Opcode classifier: maps the 4-bit opcode to an instruction class plus a legal flag.
// Latency: purely combinational.
// Backpressure: not applicable.
module decodificador_opcode
    import mips_pkg::*;
#(
    parameter logic [3:0] OP_TIPO_R = OPC_TIPO_R,
    parameter logic [3:0] OP_ADDI   = OPC_ADDI,
    parameter logic [3:0] OP_SLTI   = OPC_SLTI,
    parameter logic [3:0] OP_BEQ    = OPC_BEQ,
    parameter logic [3:0] OP_LW     = OPC_LW,
    parameter logic [3:0] OP_SW     = OPC_SW,
    parameter logic [3:0] OP_J      = OPC_J
) (
    input  logic [3:0] opcode,
    output classe_t    classe,
    output logic       legal
);

    // Any opcode not matching a known class is flagged illegal
    always_comb begin
        classe = CL_INVALIDA;
        legal  = 1'b1;
        if      (opcode == OP_TIPO_R) classe = CL_TIPO_R;
        else if (opcode == OP_ADDI)   classe = CL_ADDI;
        else if (opcode == OP_SLTI)   classe = CL_SLTI;
        else if (opcode == OP_BEQ)    classe = CL_BEQ;
        else if (opcode == OP_LW)     classe = CL_LW;
        else if (opcode == OP_SW)     classe = CL_SW;
        else if (opcode == OP_J)      classe = CL_J;
        else                          legal  = 1'b0;
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multi-cycle MIPS-like control unit: BUSCA/DECODIFICA/EXECUTA/MEMORIA/ESCRITA sequencer.
// Latency: R/ADDI/SLTI 4, LW 5, SW 4, BEQ/J 3 cycles with memory always ready; jump-register via MULTICICLO_JR_EN.
// Backpressure: BUSCA and MEMORIA stall while mem_pronto=0; reset overrides everything.
module unidade_controle_multiciclo
    import mips_pkg::*;
#(
    parameter logic [3:0] OP_TIPO_R = 4'b0000,
    parameter logic [3:0] OP_ADDI   = 4'b0001,
    parameter logic [3:0] OP_SLTI   = 4'b0010,
    parameter logic [3:0] OP_BEQ    = 4'b0011,
    parameter logic [3:0] OP_LW     = 4'b0100,
    parameter logic [3:0] OP_SW     = 4'b0101,
    parameter logic [3:0] OP_J      = 4'b0110,
    parameter logic [3:0] FUNC_JR   = 4'b1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [3:0] funcao,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic [1:0] ula_opcode,
    output logic       ir_escreve,
    output logic       pc_escreve,
    output logic       reg_escreve,
    output logic       reg_destino,
    output logic       mem_le,
    output logic       mem_escreve,
    output logic       memoria_para_reg,
    output logic       erro,
    output logic [1:0] pc_fonte,
    output logic [1:0] ula_fonte_b,
    output logic [2:0] estado
);

`ifdef MULTICICLO_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    estado_t estado_q;
    classe_t classe_q;
    logic    jr_q;
    classe_t classe_dec;
    logic    legal_dec;
    logic    executa_jr;

    decodificador_opcode #(
        .OP_TIPO_R (OP_TIPO_R),
        .OP_ADDI   (OP_ADDI),
        .OP_SLTI   (OP_SLTI),
        .OP_BEQ    (OP_BEQ),
        .OP_LW     (OP_LW),
        .OP_SW     (OP_SW),
        .OP_J      (OP_J)
    ) u_decodificador (
        .opcode (opcode),
        .classe (classe_dec),
        .legal  (legal_dec)
    );

    assign estado     = estado_q;
    assign executa_jr = JR_EN && (classe_q == CL_TIPO_R) && jr_q;

    // State sequencing; the class is captured in DECODIFICA so later states do not depend on IR staying stable
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= BUSCA;
            classe_q <= CL_TIPO_R;
            jr_q     <= 1'b0;
            erro     <= 1'b0;
        end else begin
            case (estado_q)
                BUSCA: begin
                    if (mem_pronto) estado_q <= DECODIFICA;
                end
                DECODIFICA: begin
                    if (legal_dec) begin
                        classe_q <= classe_dec;
                        jr_q     <= (funcao == FUNC_JR);
                        estado_q <= EXECUTA;
                    end else begin
                        erro     <= 1'b1;
                        estado_q <= BUSCA;
                    end
                end
                EXECUTA: begin
                    case (classe_q)
                        CL_BEQ, CL_J: estado_q <= BUSCA;
                        CL_LW, CL_SW: estado_q <= MEMORIA;
                        default:      estado_q <= executa_jr ? BUSCA : ESCRITA;
                    endcase
                end
                MEMORIA: begin
                    if (mem_pronto) estado_q <= (classe_q == CL_LW) ? ESCRITA : BUSCA;
                end
                ESCRITA: estado_q <= BUSCA;
                default: estado_q <= BUSCA;
            endcase
        end
    end

    // Control outputs are decoded from state plus mem_pronto/zero in the same cycle, since the
    // fetch ack and the branch decision must act in the cycle they arrive; reset forces them idle
    always_comb begin
        ula_opcode       = ULA_SOMA;
        ula_fonte_b      = FONTE_B_REG;
        pc_fonte         = PC_MAIS1;
        ir_escreve       = 1'b0;
        pc_escreve       = 1'b0;
        reg_escreve      = 1'b0;
        reg_destino      = 1'b0;
        mem_le           = 1'b0;
        mem_escreve      = 1'b0;
        memoria_para_reg = 1'b0;
        if (!reset) begin
            case (estado_q)
                BUSCA: begin
                    mem_le = 1'b1;
                    if (mem_pronto) begin
                        ir_escreve = 1'b1;
                        pc_escreve = 1'b1;
                    end
                end
                EXECUTA: begin
                    case (classe_q)
                        CL_TIPO_R: begin
                            ula_opcode = ULA_TIPO_R;
                            if (executa_jr) begin
                                pc_fonte   = PC_REG_RS;
                                pc_escreve = 1'b1;
                            end
                        end
                        CL_ADDI, CL_LW, CL_SW: begin
                            ula_opcode  = ULA_SOMA;
                            ula_fonte_b = FONTE_B_IMED;
                        end
                        CL_SLTI: begin
                            ula_opcode  = ULA_SLT;
                            ula_fonte_b = FONTE_B_IMED;
                        end
                        CL_BEQ: begin
                            ula_opcode = ULA_SUB;
                            pc_fonte   = PC_DESVIO;
                            pc_escreve = zero;
                        end
                        CL_J: begin
                            pc_fonte   = PC_SALTO;
                            pc_escreve = 1'b1;
                        end
                        default: ;
                    endcase
                end
                MEMORIA: begin
                    mem_le      = (classe_q == CL_LW);
                    mem_escreve = (classe_q == CL_SW);
                end
                ESCRITA: begin
                    reg_escreve      = 1'b1;
                    reg_destino      = (classe_q == CL_TIPO_R);
                    memoria_para_reg = (classe_q == CL_LW);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multi-cycle control unit; checks are sampled 3 time units after each rising edge.
// Latency: not applicable.
// Backpressure: not applicable.
module tb_unidade_controle_multiciclo;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] opcode;
    logic [3:0] funcao;
    logic       zero;
    logic       mem_pronto;
    logic [1:0] ula_opcode;
    logic       ir_escreve;
    logic       pc_escreve;
    logic       reg_escreve;
    logic       reg_destino;
    logic       mem_le;
    logic       mem_escreve;
    logic       memoria_para_reg;
    logic       erro;
    logic [1:0] pc_fonte;
    logic [1:0] ula_fonte_b;
    logic [2:0] estado;

    int total = 0;
    int bad   = 0;

    unidade_controle_multiciclo dut (
        .clock            (clock),
        .reset            (reset),
        .opcode           (opcode),
        .funcao           (funcao),
        .zero             (zero),
        .mem_pronto       (mem_pronto),
        .ula_opcode       (ula_opcode),
        .ir_escreve       (ir_escreve),
        .pc_escreve       (pc_escreve),
        .reg_escreve      (reg_escreve),
        .reg_destino      (reg_destino),
        .mem_le           (mem_le),
        .mem_escreve      (mem_escreve),
        .memoria_para_reg (memoria_para_reg),
        .erro             (erro),
        .pc_fonte         (pc_fonte),
        .ula_fonte_b      (ula_fonte_b),
        .estado           (estado)
    );

    always #5 clock = ~clock;

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clock);
        #2;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; opcode = 4'b0001; funcao = 4'b0000; zero = 1'b0; mem_pronto = 1'b1;
        #1;
        total++;
        if ({ir_escreve, pc_escreve, reg_escreve, mem_le, mem_escreve, memoria_para_reg} !== 6'b0) begin
            bad++; $display("FAIL reset_enables got=%b exp=000000",
                {ir_escreve, pc_escreve, reg_escreve, mem_le, mem_escreve, memoria_para_reg});
        end
        total++;
        if (ula_opcode !== 2'b01) begin bad++; $display("FAIL reset_ula got=%b exp=01", ula_opcode); end
        step();
        reset = 1'b0;
        total++;
        if (estado !== 3'd0 || erro !== 1'b0) begin
            bad++; $display("FAIL reset_state estado=%0d erro=%b exp estado=0 erro=0", estado, erro);
        end
    endtask

    task automatic test_busca_wait;
        do_reset();
        opcode = 4'b0001; mem_pronto = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (estado !== 3'd0 || mem_le !== 1'b1 || ir_escreve !== 1'b0 || pc_escreve !== 1'b0) begin
                bad++; $display("FAIL busca_wait k=%0d estado=%0d mem_le=%b ir=%b pc=%b exp 0 1 0 0",
                    k, estado, mem_le, ir_escreve, pc_escreve);
            end
            step();
        end
    endtask

    task automatic test_addi;
        logic [2:0] exp_e [0:4];
        int pulses;
        exp_e = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        pulses = 0;
        do_reset();
        opcode = 4'b0001; funcao = 4'b0000; zero = 1'b0; mem_pronto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (estado !== exp_e[k]) begin
                bad++; $display("FAIL addi_estado k=%0d got=%0d exp=%0d", k, estado, exp_e[k]);
            end
            if (k == 0) begin
                total++;
                if ({ir_escreve, pc_escreve, pc_fonte} !== 4'b1100) begin
                    bad++; $display("FAIL addi_fetch got=%b exp=1100", {ir_escreve, pc_escreve, pc_fonte});
                end
            end
            if (k == 2) begin
                total++;
                if ({ula_opcode, ula_fonte_b} !== 4'b0110) begin
                    bad++; $display("FAIL addi_exec got=%b exp=0110", {ula_opcode, ula_fonte_b});
                end
            end
            if (reg_escreve === 1'b1) begin
                pulses++;
                total++;
                if (reg_destino !== 1'b0 || memoria_para_reg !== 1'b0) begin
                    bad++; $display("FAIL addi_wb rd=%b m2r=%b exp 0 0", reg_destino, memoria_para_reg);
                end
            end
            step();
        end
        total++;
        if (pulses != 1) begin bad++; $display("FAIL addi_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_slti_rtype;
        do_reset();
        opcode = 4'b0010; funcao = 4'b0000; mem_pronto = 1'b1;
        step(); step();
        #1;
        total++;
        if (estado !== 3'd2 || ula_opcode !== 2'b10 || ula_fonte_b !== 2'b10) begin
            bad++; $display("FAIL slti_exec estado=%0d ula=%b fb=%b exp 2 10 10", estado, ula_opcode, ula_fonte_b);
        end
        do_reset();
        opcode = 4'b0000; funcao = 4'b0010;
        step(); step();
        #1;
        total++;
        if (estado !== 3'd2 || ula_opcode !== 2'b00 || ula_fonte_b !== 2'b00 || pc_escreve !== 1'b0) begin
            bad++; $display("FAIL rtype_exec estado=%0d ula=%b fb=%b pc=%b exp 2 00 00 0",
                estado, ula_opcode, ula_fonte_b, pc_escreve);
        end
        step();
        #1;
        total++;
        if (estado !== 3'd4 || reg_escreve !== 1'b1 || reg_destino !== 1'b1) begin
            bad++; $display("FAIL rtype_wb estado=%0d we=%b rd=%b exp 4 1 1", estado, reg_escreve, reg_destino);
        end
    endtask

    task automatic test_lw_wait;
        logic [2:0] exp_e [0:8];
        int waits;
        exp_e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        waits = 0;
        do_reset();
        opcode = 4'b0100; funcao = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            mem_pronto = !(k >= 3 && k <= 5);
            #1;
            total++;
            if (estado !== exp_e[k]) begin
                bad++; $display("FAIL lw_estado k=%0d got=%0d exp=%0d", k, estado, exp_e[k]);
            end
            if (k >= 3 && k <= 6) begin
                total++;
                if (mem_le !== 1'b1 || mem_escreve !== 1'b0) begin
                    bad++; $display("FAIL lw_mem k=%0d le=%b wr=%b exp 1 0", k, mem_le, mem_escreve);
                end
                if (k <= 5 && mem_le === 1'b1) waits++;
            end
            if (k == 7) begin
                total++;
                if ({reg_escreve, memoria_para_reg, reg_destino} !== 3'b110) begin
                    bad++; $display("FAIL lw_wb got=%b exp=110", {reg_escreve, memoria_para_reg, reg_destino});
                end
            end
            step();
        end
        total++;
        if (waits != 3) begin bad++; $display("FAIL lw_wait_cycles got=%0d exp=3", waits); end
    endtask

    task automatic test_sw;
        logic [2:0] exp_e [0:4];
        exp_e = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        opcode = 4'b0101; mem_pronto = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++;
            if (estado !== exp_e[k]) begin
                bad++; $display("FAIL sw_estado k=%0d got=%0d exp=%0d", k, estado, exp_e[k]);
            end
            if (k == 3) begin
                total++;
                if (mem_escreve !== 1'b1 || mem_le !== 1'b0 || reg_escreve !== 1'b0) begin
                    bad++; $display("FAIL sw_mem wr=%b le=%b we=%b exp 1 0 0", mem_escreve, mem_le, reg_escreve);
                end
            end
            step();
        end
    endtask

    task automatic test_beq_j;
        logic [3:0] ops [0:2];
        logic       zs  [0:2];
        logic       pcw [0:2];
        logic [1:0] pcf [0:2];
        ops = '{4'b0011, 4'b0011, 4'b0110};
        zs  = '{1'b1, 1'b0, 1'b0};
        pcw = '{1'b1, 1'b0, 1'b1};
        pcf = '{2'b01, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            opcode = ops[i]; zero = zs[i]; mem_pronto = 1'b1;
            step();
            #1;
            total++;
            if (estado !== 3'd1 || pc_escreve !== 1'b0) begin
                bad++; $display("FAIL br%0d_dec estado=%0d pc=%b exp 1 0", i, estado, pc_escreve);
            end
            step();
            #1;
            total++;
            if (estado !== 3'd2 || pc_escreve !== pcw[i] || pc_fonte !== pcf[i]) begin
                bad++; $display("FAIL br%0d_exec estado=%0d pc=%b src=%b exp 2 %b %b",
                    i, estado, pc_escreve, pc_fonte, pcw[i], pcf[i]);
            end
            if (i < 2) begin
                total++;
                if (ula_opcode !== 2'b11) begin bad++; $display("FAIL br%0d_ula got=%b exp=11", i, ula_opcode); end
            end
            step();
            #1;
            total++;
            if (estado !== 3'd0) begin bad++; $display("FAIL br%0d_ret got=%0d exp=0", i, estado); end
        end
        zero = 1'b0;
    endtask

    task automatic test_illegal;
        do_reset();
        opcode = 4'b1111; mem_pronto = 1'b1;
        step();
        #1;
        total++;
        if (estado !== 3'd1 || erro !== 1'b0 || pc_escreve !== 1'b0 || reg_escreve !== 1'b0) begin
            bad++; $display("FAIL ill_dec estado=%0d erro=%b exp 1 0", estado, erro);
        end
        step();
        #1;
        total++;
        if (estado !== 3'd0 || erro !== 1'b1) begin
            bad++; $display("FAIL ill_after estado=%0d erro=%b exp 0 1", estado, erro);
        end
        opcode = 4'b0001;
        for (int k = 0; k < 4; k++) step();
        #1;
        total++;
        if (estado !== 3'd0 || erro !== 1'b1) begin
            bad++; $display("FAIL ill_sticky estado=%0d erro=%b exp 0 1", estado, erro);
        end
        do_reset();
        #1;
        total++;
        if (erro !== 1'b0) begin bad++; $display("FAIL ill_clear got=%b exp=0", erro); end
    endtask

    task automatic test_jr;
        do_reset();
        opcode = 4'b0000; funcao = 4'b1000; mem_pronto = 1'b1;
        step(); step();
        #1;
`ifdef MULTICICLO_JR_EN
        total++;
        if (estado !== 3'd2 || pc_escreve !== 1'b1 || pc_fonte !== 2'b11) begin
            bad++; $display("FAIL jr_exec estado=%0d pc=%b src=%b exp 2 1 11", estado, pc_escreve, pc_fonte);
        end
        step();
        #1;
        total++;
        if (estado !== 3'd0 || reg_escreve !== 1'b0) begin
            bad++; $display("FAIL jr_ret estado=%0d we=%b exp 0 0", estado, reg_escreve);
        end
`else
        total++;
        if (estado !== 3'd2 || pc_escreve !== 1'b0) begin
            bad++; $display("FAIL jr_exec estado=%0d pc=%b exp 2 0", estado, pc_escreve);
        end
        step();
        #1;
        total++;
        if (estado !== 3'd4 || reg_escreve !== 1'b1 || reg_destino !== 1'b1) begin
            bad++; $display("FAIL jr_wb estado=%0d we=%b rd=%b exp 4 1 1", estado, reg_escreve, reg_destino);
        end
`endif
        funcao = 4'b0000;
    endtask

    task automatic test_reset_mid_sw;
        do_reset();
        opcode = 4'b0101; mem_pronto = 1'b1;
        step(); step();
        mem_pronto = 1'b0;
        step(); step();
        #1;
        total++;
        if (estado !== 3'd3 || mem_escreve !== 1'b1) begin
            bad++; $display("FAIL midsw_mem estado=%0d wr=%b exp 3 1", estado, mem_escreve);
        end
        reset = 1'b1;
        #1;
        total++;
        if (mem_escreve !== 1'b0 || mem_le !== 1'b0 || ula_opcode !== 2'b01) begin
            bad++; $display("FAIL midsw_rst_cycle wr=%b le=%b ula=%b exp 0 0 01", mem_escreve, mem_le, ula_opcode);
        end
        step();
        reset = 1'b0;
        #1;
        total++;
        if (estado !== 3'd0 || mem_escreve !== 1'b0) begin
            bad++; $display("FAIL midsw_after estado=%0d wr=%b exp 0 0", estado, mem_escreve);
        end
    endtask

    initial begin
        test_reset();
        test_busca_wait();
        test_addi();
        test_slti_rtype();
        test_lw_wait();
        test_sw();
        test_beq_j();
        test_illegal();
        test_jr();
        test_reset_mid_sw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
